// File: rtl/compressor_4_2_tree_acc_if.sv
// Handshake bundle for compressor_4_2_tree_acc.
//   master : beat producer / result consumer (drives in_*, out_ready_i)
//   slave  : the reduction + accumulate datapath
// Signals:
//   in_valid_i / in_ready_o / in_data_i (N_IN*WIDTH) / in_last_i  : operand beats
//   out_valid_o / out_ready_i / out_sum_o (ACC_WIDTH) / out_beats_o (CNT_WIDTH) : packet results
interface compressor_4_2_tree_acc_if #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned N_IN      = 4,
    parameter int unsigned ACC_WIDTH = WIDTH + 16,
    parameter int unsigned CNT_WIDTH = 16
);
    logic                      in_valid_i;
    logic                      in_ready_o;
    logic [N_IN*WIDTH-1:0]     in_data_i;
    logic                      in_last_i;
    logic                      out_valid_o;
    logic                      out_ready_i;
    logic [ACC_WIDTH-1:0]      out_sum_o;
    logic [CNT_WIDTH-1:0]      out_beats_o;

    modport master (
        output in_valid_i, in_data_i, in_last_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_sum_o, out_beats_o
    );

    modport slave (
        input  in_valid_i, in_data_i, in_last_i, out_ready_i,
        output in_ready_o, out_valid_o, out_sum_o, out_beats_o
    );
endinterface

// File: rtl/compressor_4_2_tree_acc.sv
// Pipelined multi-operand signed adder: N_IN sign-extended operands per beat are reduced
// to carry-save form by log2(N_IN)-1 registered levels of 4:2 compressor rows, accumulated
// across the beats of a packet in carry-save form, and resolved by one carry-propagate add
// when the packet's last beat leaves the accumulator.
// Ports:
//   clk_i   : clock, rising edge
//   rst_ni  : asynchronous active-low reset
//   bus_io  : slave side of the beat/result handshake (see compressor_4_2_tree_acc_if)
// A stalled result (out_valid_o & ~out_ready_i) freezes the whole pipeline; no skid buffers.
// ACC_WIDTH must exceed WIDTH.
module compressor_4_2_tree_acc #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned N_IN      = 4,
    parameter int unsigned ACC_WIDTH = WIDTH + 16,
    parameter int unsigned CNT_WIDTH = 16
) (
    input logic                       clk_i,
    input logic                       rst_ni,
    compressor_4_2_tree_acc_if.slave  bus_io
);
    // Tree depth; the final level leaves exactly two vectors (sum, carry).
    localparam int unsigned T     = $clog2(N_IN) - 1;
    // Node list: level l occupies N_IN>>l entries starting at 2*N_IN - 2*(N_IN>>l).
    localparam int unsigned NNode = 2 * N_IN - 2;
    // Registered part of the node list (levels 1..T).
    localparam int unsigned NTree = N_IN - 2;

    // Bitwise 4:2 row: two full-adder layers, lateral carries and output carries shifted
    // left by one, bits above ACC_WIDTH dropped. Returns {carry, sum}.
    function automatic logic [2*ACC_WIDTH-1:0] comp42(input logic [ACC_WIDTH-1:0] a,
                                                      input logic [ACC_WIDTH-1:0] b,
                                                      input logic [ACC_WIDTH-1:0] c,
                                                      input logic [ACC_WIDTH-1:0] d);
        logic [ACC_WIDTH-1:0] s1, c1, cin, s, cy;
        s1  = a ^ b ^ c;
        c1  = (a & b) | (a & c) | (b & c);
        cin = c1 << 1;
        s   = s1 ^ d ^ cin;
        cy  = ((s1 & d) | (s1 & cin) | (d & cin)) << 1;
        return {cy, s};
    endfunction

    logic                 en;
    logic [ACC_WIDTH-1:0] node   [NNode];
    logic [ACC_WIDTH-1:0] tree_d [NTree];
    logic [ACC_WIDTH-1:0] tree_q [NTree];
    logic [T-1:0]         vld_d, vld_q, last_d, last_q;

    logic [ACC_WIDTH-1:0] acc_s_d, acc_s_q, acc_c_d, acc_c_q;
    logic                 first_d, first_q;
    logic                 acc_vld_d, acc_vld_q, acc_last_d, acc_last_q;
    logic [CNT_WIDTH-1:0] cnt_d, cnt_q;
    logic [ACC_WIDTH-1:0] row_s, row_c;

    logic                 out_valid_d, out_valid_q;
    logic [ACC_WIDTH-1:0] out_sum_d, out_sum_q;
    logic [CNT_WIDTH-1:0] out_beats_d, out_beats_q;

    assign en = ~(out_valid_q & ~bus_io.out_ready_i);

    // Level 0 is the sign-extended input; higher levels come from the tree registers.
    always_comb begin
        for (int k = 0; k < int'(N_IN); k++) begin
            node[k] = {{(ACC_WIDTH - WIDTH){bus_io.in_data_i[k*WIDTH + WIDTH - 1]}},
                       bus_io.in_data_i[k*WIDTH +: WIDTH]};
        end
        for (int j = 0; j < int'(NTree); j++) begin
            node[N_IN + j] = tree_q[j];
        end
    end

    always_comb begin
        logic [2*ACC_WIDTH-1:0] r;
        int                     src, dst;
        r   = '0;
        src = 0;
        dst = 0;
        for (int j = 0; j < int'(NTree); j++) begin
            tree_d[j] = '0;
        end
        for (int l = 0; l < int'(T); l++) begin
            src = 2 * int'(N_IN) - 2 * (int'(N_IN) >> l);
            dst = 2 * int'(N_IN) - 2 * (int'(N_IN) >> (l + 1)) - int'(N_IN);
            for (int i = 0; i < (int'(N_IN) >> (l + 2)); i++) begin
                r = comp42(node[src + 4*i], node[src + 4*i + 1],
                           node[src + 4*i + 2], node[src + 4*i + 3]);
                tree_d[dst + 2*i]     = r[ACC_WIDTH-1:0];
                tree_d[dst + 2*i + 1] = r[2*ACC_WIDTH-1:ACC_WIDTH];
            end
        end
    end

    always_comb begin
        vld_d     = vld_q;
        last_d    = last_q;
        vld_d[0]  = bus_io.in_valid_i;
        last_d[0] = bus_io.in_last_i;
        for (int l = 1; l < int'(T); l++) begin
            vld_d[l]  = vld_q[l-1];
            last_d[l] = last_q[l-1];
        end
    end

    // Accumulate stage: the carry-save accumulator is ignored on the first beat of a packet.
    always_comb begin
        {row_c, row_s} = comp42(tree_q[NTree-2], tree_q[NTree-1],
                                first_q ? '0 : acc_s_q, first_q ? '0 : acc_c_q);
        acc_s_d    = acc_s_q;
        acc_c_d    = acc_c_q;
        first_d    = first_q;
        cnt_d      = cnt_q;
        acc_vld_d  = vld_q[T-1];
        acc_last_d = last_q[T-1];
        if (vld_q[T-1]) begin
            acc_s_d = row_s;
            acc_c_d = row_c;
            first_d = last_q[T-1];
            if (first_q) begin
                cnt_d = CNT_WIDTH'(1);
            end else if (cnt_q != {CNT_WIDTH{1'b1}}) begin
                cnt_d = cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    // Output stage only advances when en=1, so a pending result is implicitly consumed here.
    always_comb begin
        out_valid_d = acc_vld_q & acc_last_q;
        out_sum_d   = out_sum_q;
        out_beats_d = out_beats_q;
        if (acc_vld_q & acc_last_q) begin
            out_sum_d   = acc_s_q + acc_c_q;
            out_beats_d = cnt_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int j = 0; j < int'(NTree); j++) begin
                tree_q[j] <= '0;
            end
            vld_q       <= '0;
            last_q      <= '0;
            acc_s_q     <= '0;
            acc_c_q     <= '0;
            first_q     <= 1'b1;
            acc_vld_q   <= 1'b0;
            acc_last_q  <= 1'b0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_beats_q <= '0;
        end else if (en) begin
            tree_q      <= tree_d;
            vld_q       <= vld_d;
            last_q      <= last_d;
            acc_s_q     <= acc_s_d;
            acc_c_q     <= acc_c_d;
            first_q     <= first_d;
            acc_vld_q   <= acc_vld_d;
            acc_last_q  <= acc_last_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_beats_q <= out_beats_d;
        end
    end

    assign bus_io.in_ready_o  = en;
    assign bus_io.out_valid_o = out_valid_q;
    assign bus_io.out_sum_o   = out_sum_q;
    assign bus_io.out_beats_o = out_beats_q;
endmodule
